// File: rtl/gpio_pattern_gen.sv
// GPIO bring-up exerciser: walking-one/zero, binary count and pin-ID serial patterns.
// Latency: all outputs registered; seq/gpio_out/wrap update on the edge where tick is true.
// No backpressure: enable_i=0 freezes every piece of state, reset_i overrides everything.
module gpio_pattern_gen #(
  parameter int NUM_PINS = 32,
  parameter int DIV_W    = 24
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic [1:0]          mode_i,
  input  logic [DIV_W-1:0]    div_i,
  output logic [NUM_PINS-1:0] gpio_out_o,
  output logic [7:0]          seq_o,
  output logic                wrap_o
);

  localparam int ID_W = $clog2(NUM_PINS);

  logic [DIV_W-1:0]    cnt_q,  cnt_d;
  logic [7:0]          seq_q,  seq_d;
  logic [1:0]          mode_q, mode_d;
  logic [NUM_PINS-1:0] gpio_q, gpio_d;
  logic                wrap_q, wrap_d;
  logic                tick;

  // Last step index of the sequence for a given mode (sequence length minus one).
  function automatic logic [7:0] last_step(input logic [1:0] m);
    case (m)
      2'd0, 2'd1: last_step = 8'(NUM_PINS - 1);
      2'd2:       last_step = 8'd255;
      default:    last_step = 8'(ID_W + 2);
    endcase
  endfunction

  // Output pattern for step s of mode m; pin-ID frame is start 0, ID MSB first, stop 1, idle 1.
  function automatic logic [NUM_PINS-1:0] pattern(input logic [7:0] s, input logic [1:0] m);
    logic [NUM_PINS-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      case (m)
        2'd0: p[i] = (s == 8'(i));
        2'd1: p[i] = (s != 8'(i));
        2'd2: p[i] = s[3'(i % 8)];
        default: begin
          if (s == 8'd0)
            p[i] = 1'b0;
          else if (s <= 8'(ID_W))
            p[i] = (((i >> (ID_W - int'(s))) & 1) != 0);
          else
            p[i] = 1'b1;
        end
      endcase
    end
    return p;
  endfunction

  // Prescaler terminal count; lowering div_i below cnt_q fires on the next enabled cycle.
  assign tick = enable_i && (cnt_q >= div_i);

  // Next-state: prescaler, step sequencer with mode latch, wrap strobe and pattern.
  always_comb begin
    cnt_d  = cnt_q;
    seq_d  = seq_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (enable_i) begin
      if (tick) begin
        cnt_d = '0;
        if (mode_i != mode_q) begin
          // New pattern starts cleanly at step 0 and is not reported as a wrap.
          mode_d = mode_i;
          seq_d  = 8'd0;
        end else if (seq_q == last_step(mode_q)) begin
          seq_d  = 8'd0;
          wrap_d = 1'b1;
        end else begin
          seq_d = seq_q + 8'd1;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
    gpio_d = pattern(seq_d, mode_d);
  end

  // State registers with synchronous reset to walking-one step 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      seq_q  <= 8'd0;
      mode_q <= 2'd0;
      gpio_q <= NUM_PINS'(1);
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seq_q  <= seq_d;
      mode_q <= mode_d;
      gpio_q <= gpio_d;
      wrap_q <= wrap_d;
    end
  end

  assign gpio_out_o = gpio_q;
  assign seq_o      = seq_q;
  assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Directed bench for gpio_pattern_gen with NUM_PINS=32, DIV_W=24.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_gpio_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] div;
  logic [31:0] gpio_out;
  logic [7:0]  seq;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  gpio_pattern_gen #(.NUM_PINS(32), .DIV_W(24)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .mode_i     (mode),
    .div_i      (div),
    .gpio_out_o (gpio_out),
    .seq_o      (seq),
    .wrap_o     (wrap)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset for one edge with the given settings, then release.
  task automatic restart(input logic [1:0] m, input logic [23:0] d);
    reset = 1'b1; enable = 1'b1; mode = m; div = d;
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; mode = 2'd0; div = 24'd0;
    step(2);
    checks++; if (gpio_out !== 32'h0000_0001) begin errors++; $display("FAIL reset_gpio: got %h exp 00000001", gpio_out); end
    checks++; if (seq !== 8'd0) begin errors++; $display("FAIL reset_seq: got %0d exp 0", seq); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b exp 0", wrap); end
  endtask

  task automatic test_walking_one;
    logic [31:0] exp;
    restart(2'd0, 24'd0);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      exp = 32'd1 << (k % 32);
      checks++; if (gpio_out !== exp) begin errors++; $display("FAIL w1_gpio k=%0d: got %h exp %h", k, gpio_out, exp); end
      checks++; if (wrap !== (k % 32 == 0)) begin errors++; $display("FAIL w1_wrap k=%0d: got %b exp %b", k, wrap, (k % 32 == 0)); end
    end
  endtask

  task automatic test_walking_zero;
    restart(2'd1, 24'd3);
    step(3);
    checks++; if (gpio_out !== 32'h0000_0001) begin errors++; $display("FAIL w0_pre: got %h exp 00000001", gpio_out); end
    step(1);
    checks++; if (gpio_out !== 32'hFFFF_FFFE || seq !== 8'd0) begin errors++; $display("FAIL w0_s0: got %h/%0d exp fffffffe/0", gpio_out, seq); end
    step(3);
    checks++; if (gpio_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL w0_hold: got %h exp fffffffe", gpio_out); end
    step(1);
    checks++; if (gpio_out !== 32'hFFFF_FFFD || seq !== 8'd1) begin errors++; $display("FAIL w0_s1: got %h/%0d exp fffffffd/1", gpio_out, seq); end
    step(4);
    checks++; if (gpio_out !== 32'hFFFF_FFFB || seq !== 8'd2) begin errors++; $display("FAIL w0_s2: got %h/%0d exp fffffffb/2", gpio_out, seq); end
  endtask

  task automatic test_binary_count;
    restart(2'd2, 24'd0);
    step(1);
    checks++; if (gpio_out !== 32'h0 || seq !== 8'd0 || wrap !== 1'b0) begin errors++; $display("FAIL bc_switch: got %h/%0d/%b exp 0/0/0", gpio_out, seq, wrap); end
    step(5);
    checks++; if (gpio_out !== 32'h0505_0505 || seq !== 8'd5) begin errors++; $display("FAIL bc_5: got %h/%0d exp 05050505/5", gpio_out, seq); end
    step(250);
    checks++; if (gpio_out !== 32'hFFFF_FFFF || seq !== 8'd255 || wrap !== 1'b0) begin errors++; $display("FAIL bc_255: got %h/%0d/%b exp ffffffff/255/0", gpio_out, seq, wrap); end
    step(1);
    checks++; if (seq !== 8'd0 || wrap !== 1'b1) begin errors++; $display("FAIL bc_wrap: got %0d/%b exp 0/1", seq, wrap); end
    step(1);
    checks++; if (seq !== 8'd1 || wrap !== 1'b0 || gpio_out !== 32'h0101_0101) begin errors++; $display("FAIL bc_after: got %0d/%b/%h exp 1/0/01010101", seq, wrap, gpio_out); end
  endtask

  task automatic test_pin_id;
    logic p5  [8];
    logic p31 [8];
    logic p0  [8];
    p5  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    p31 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    p0  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    restart(2'd3, 24'd0);
    step(1);
    for (int s = 0; s < 8; s++) begin
      checks++; if (seq !== 8'(s)) begin errors++; $display("FAIL pid_seq: got %0d exp %0d", seq, s); end
      checks++; if (gpio_out[5] !== p5[s]) begin errors++; $display("FAIL pid_pin5 step %0d: got %b exp %b", s, gpio_out[5], p5[s]); end
      checks++; if (gpio_out[31] !== p31[s]) begin errors++; $display("FAIL pid_pin31 step %0d: got %b exp %b", s, gpio_out[31], p31[s]); end
      checks++; if (gpio_out[0] !== p0[s]) begin errors++; $display("FAIL pid_pin0 step %0d: got %b exp %b", s, gpio_out[0], p0[s]); end
      step(1);
    end
    checks++; if (wrap !== 1'b1 || seq !== 8'd0) begin errors++; $display("FAIL pid_wrap1: got %b/%0d exp 1/0", wrap, seq); end
    step(1);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL pid_nowrap: got %b exp 0", wrap); end
    step(7);
    checks++; if (wrap !== 1'b1 || seq !== 8'd0) begin errors++; $display("FAIL pid_wrap2: got %b/%0d exp 1/0", wrap, seq); end
  endtask

  task automatic test_mode_change;
    restart(2'd0, 24'd0);
    step(17);
    checks++; if (seq !== 8'd17 || gpio_out !== 32'h0002_0000) begin errors++; $display("FAIL mc_pre: got %0d/%h exp 17/00020000", seq, gpio_out); end
    mode = 2'd2;
    step(1);
    checks++; if (seq !== 8'd0 || gpio_out !== 32'h0 || wrap !== 1'b0) begin errors++; $display("FAIL mc_switch: got %0d/%h/%b exp 0/0/0", seq, gpio_out, wrap); end
    div = 24'd9;
    step(3); mode = 2'd0;
    step(3); mode = 2'd2;
    step(3);
    checks++; if (seq !== 8'd0) begin errors++; $display("FAIL mc_wait: got %0d exp 0", seq); end
    step(1);
    checks++; if (seq !== 8'd1 || gpio_out !== 32'h0101_0101 || wrap !== 1'b0) begin errors++; $display("FAIL mc_toggle: got %0d/%h/%b exp 1/01010101/0", seq, gpio_out, wrap); end
  endtask

  task automatic test_enable_freeze;
    restart(2'd0, 24'd9);
    step(5);
    enable = 1'b0;
    step(50);
    checks++; if (seq !== 8'd0 || gpio_out !== 32'h1 || wrap !== 1'b0) begin errors++; $display("FAIL en_frozen: got %0d/%h/%b exp 0/00000001/0", seq, gpio_out, wrap); end
    enable = 1'b1;
    step(4);
    checks++; if (seq !== 8'd0) begin errors++; $display("FAIL en_remain: got %0d exp 0", seq); end
    step(1);
    checks++; if (seq !== 8'd1 || gpio_out !== 32'h2) begin errors++; $display("FAIL en_step: got %0d/%h exp 1/00000002", seq, gpio_out); end
  endtask

  task automatic test_div_drop;
    restart(2'd0, 24'd100);
    step(50);
    checks++; if (seq !== 8'd0) begin errors++; $display("FAIL dd_pre: got %0d exp 0", seq); end
    div = 24'd2;
    step(1);
    checks++; if (seq !== 8'd1 || gpio_out !== 32'h2) begin errors++; $display("FAIL dd_tick: got %0d/%h exp 1/00000002", seq, gpio_out); end
  endtask

  task automatic test_reset_with_tick;
    restart(2'd0, 24'd0);
    step(31);
    checks++; if (seq !== 8'd31) begin errors++; $display("FAIL rt_pre: got %0d exp 31", seq); end
    reset = 1'b1;
    step(1);
    checks++; if (gpio_out !== 32'h1 || seq !== 8'd0 || wrap !== 1'b0) begin errors++; $display("FAIL rt_reset: got %h/%0d/%b exp 00000001/0/0", gpio_out, seq, wrap); end
    reset = 1'b0;
    step(1);
    checks++; if (gpio_out !== 32'h2 || seq !== 8'd1) begin errors++; $display("FAIL rt_after: got %h/%0d exp 00000002/1", gpio_out, seq); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'd0; div = 24'd0;
    #1;
    test_reset;
    test_walking_one;
    test_walking_zero;
    test_binary_count;
    test_pin_id;
    test_mode_change;
    test_enable_freeze;
    test_div_drop;
    test_reset_with_tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_pattern_gen.md
# gpio_pattern_gen

Parametrised GPIO exerciser for board bring-up: drives `NUM_PINS` outputs with one of four selectable test patterns, advanced at a programmable step rate derived from the single system clock. It replaces the fixed-width, single-pattern GPIO sequencer in bring-up top levels. It adds three capabilities:

- runtime mode selection,
- a pin-identifying serial mode,
- a wrap strobe for logic-analyser triggering.

## Interface
- `NUM_PINS`, 32, number of driven GPIOs; legal range 2..64.
- `DIV_W`, 24, width of step-period divider.
- Derived (local, not overridable): `ID_W` = `$clog2(NUM_PINS)`.
- `clk` in 1, system clock (12 MHz on target board).
- `reset` in 1, one clock; reset is synchronous and active-high.
- `enable` in 1, 1 = run prescaler and sequencer; 0 = freeze all state.
- `mode` in 2, pattern select:
  - 0 walking-one
  - 1 walking-zero
  - 2 binary count
  - 3 pin-ID serial
- `div` in DIV_W, step period minus one, in `clk` cycles.
- `gpio_out` out NUM_PINS, registered pattern outputs.
- `seq` out 8, current step index.
- `wrap` out 1, one-cycle pulse when `seq` wraps to 0.

## Operation
- **Prescaler**
  - `cnt` (DIV_W bits) increments each enabled cycle.
  - `tick` is asserted when `cnt >= div`; `cnt` then reloads 0.
  - With `div` = 0, a tick occurs every enabled cycle.
  - Lowering `div` below the current `cnt` produces a tick on the next enabled cycle.
- **Sequence length L**
  - modes 0/1: L = NUM_PINS
  - mode 2: L = 256
  - mode 3: L = ID_W+3
- **On tick, mode unchanged:** `seq` <= (`seq` == L-1) ? 0 : `seq`+1.
- **On tick, `mode` differs from latched `mode_r`:** `mode_r` <= `mode`, `seq` <= 0, `wrap` stays 0.
- `mode` is sampled only on tick; between ticks it is ignored.
- **Pattern functions** (each output bit `i`):
  - mode 0: `gpio_out[i]` = (i == seq).
  - mode 1: `gpio_out[i]` = (i != seq).
  - mode 2: `gpio_out[i]` = `seq[i % 8]`.
  - mode 3 (per-pin serial frame, all pins in lockstep):
    - step 0: start bit 0
    - steps 1..ID_W: bit (ID_W-step) of `i`, i.e. MSB first
    - step ID_W+1: stop bit 1
    - step ID_W+2: idle 1
- **`wrap`:** 1 for exactly the cycle following a tick that moved `seq` from L-1 to 0 without a mode change; otherwise 0.
- **`enable` = 0:** `cnt`, `seq`, `mode_r`, `gpio_out` hold; `wrap` is 0.
- **Reset** (highest priority, overrides tick/enable):
  - `cnt` = 0, `seq` = 0, `mode_r` = 0, `wrap` = 0
  - `gpio_out` = 1 in bit 0, 0 elsewhere (walking-one step 0)
- **Reset mid-frame:** no partial completion; the next pattern starts at step 0 of mode 0 on the first tick.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `seq`, `gpio_out` and `wrap` update on the same edge: the edge at which `tick` is evaluated true.
- The `gpio_out` value always equals the pattern function of the registered `seq`/`mode_r`.
- **Step period:** `div`+1 enabled cycles.
- **Mode latency:** a new pattern appears at the first tick after `mode` changes, at `seq` 0.
- **First tick after reset deassertion, with `enable` = 1:** occurs at edge `div`+1 counted from the first non-reset edge.

## Test plan
- **Reset/walking-one:** NUM_PINS=32, div=0, mode=0, enable=1; release reset.
  - After k edges: `gpio_out` = 1<<(k%32).
  - `wrap` pulses once every 32 cycles, on the cycle where `gpio_out` returns to 0x00000001.
- **Walking-zero + divider:** div=3, mode=1.
  - `gpio_out` changes every 4 cycles: 0xFFFFFFFE → 0xFFFFFFFD → …
  - `seq` steps 0,1,2 at 4-cycle spacing.
- **Binary count:** mode=2, div=0.
  - After 5 ticks: `seq` = 0x05 and `gpio_out` = 0x05050505.
  - After 256 ticks: `seq` = 0 and `wrap` = 1 for one cycle.
- **Pin-ID serial:** mode=3, div=0, NUM_PINS=32 (ID_W=5, L=8).
  - Pin 5 over steps 0..7 = 0,0,0,1,0,1,1,1.
  - Pin 31 = 0,1,1,1,1,1,1,1.
  - `wrap` every 8 ticks.
- **Mode change mid-sequence:**
  - Set mode 0 with `seq`=17, then switch to mode=2.
  - Next tick: `seq` = 0, `gpio_out` = 0x00000000, `wrap` = 0.
  - With `div`=9, `mode` toggled 0→2→0 between ticks has no effect.
- **Enable/reset corners:**
  - `enable`=0 for 50 cycles mid-step: `gpio_out`/`seq` frozen; the step completes after the remaining count once re-enabled.
  - `div` dropped from 100 to 2 while `cnt`=50: tick on the next cycle.
  - `reset` asserted concurrently with a tick: outputs go to reset values (`gpio_out`=0x00000001, `seq`=0, `wrap`=0).
